rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter for the integer register file's single write port. Three producers compete for the port: the ALU pipe, the load/store unit and the multiply/divide unit. Each cycle the block grants at most one non-x0 write and drives the registered `we/waddr/wdata` into the regfile. Bounded-wait aging stops the ALU from starving the LSU and MDU.

## Interface
- `XLEN`, default 64: write data width.
- `STARVE_LIMIT`, default 4: number of consecutive denied cycles after which a low-priority source pre-empts the ALU. Legal range is 1..15.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `alu_valid` in 1, `alu_ready` out 1, `alu_waddr` in 5, `alu_wdata` in XLEN: ALU write request.
- `lsu_valid` in 1, `lsu_ready` out 1, `lsu_waddr` in 5, `lsu_wdata` in XLEN: load write request.
- `mdu_valid` in 1, `mdu_ready` out 1, `mdu_waddr` in 5, `mdu_wdata` in XLEN: mul/div write request.
- `rf_we` out 1, `rf_waddr` out 5, `rf_wdata` out XLEN: regfile write port, registered.
- `grant_src` out 2: source of the current `rf_we`, registered. Encoding: ALU=0, LSU=1, MDU=2, NONE=3.

## Operation
- **Handshake.** A transfer occurs when `valid & ready`. A requester holds `valid`, `waddr` and `wdata` stable until the transfer. `valid` must not depend on `ready`.
- **x0 requests.**
  - A valid request with `waddr==0` gets `ready=1` in the same cycle, unconditionally.
  - It produces no write and does not count as a grant.
  - It leaves the wait counters and `rr` unchanged.
  - Several x0 requests in one cycle are all accepted.
- **Priority among non-x0 requests** (at most one granted per cycle):
  - Starving set S = {LSU, MDU sources whose wait counter == STARVE_LIMIT and which are valid}.
  - If S is non-empty, grant within S. If both are in S, `rr` decides. `alu_ready=0` that cycle.
  - Else, if the ALU is valid, grant the ALU.
  - Else, grant between LSU and MDU by `rr`: rr=0 prefers LSU, rr=1 prefers MDU.
- **`rr`.** After an LSU grant, `rr<=1`. After an MDU grant, `rr<=0`. It is unchanged otherwise.
- **Wait counters** (`lsu_wait`, `mdu_wait`, 4 bits each):
  - Increment when the source is valid with non-x0 `waddr` and not granted. Saturate at STARVE_LIMIT.
  - Clear on a grant to that source, or when the source is not valid.
- **Output register.**
  - On a grant: `rf_we<=1`, `rf_waddr/rf_wdata` <= the granted request, `grant_src<=` its source.
  - Otherwise: `rf_we<=0`, `grant_src<=NONE`, and `rf_waddr/rf_wdata` hold their values.
- **Same `waddr` from two sources in one cycle.** Only the granted source writes; the other waits. WAW ordering is the issue logic's responsibility.
- **While `rst_n` is low,** all `ready` outputs are 0.

## Timing
- Reset values: `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `grant_src=NONE(3)`, `rr=0`, both wait counters 0.
- Reset acts immediately on assertion. This includes mid-write: a pending `rf_we` drops without a clock edge.
- `ready` is a combinational function of the valids, the `waddr==0` checks, the wait counters, `rr` and `rst_n`. There is no path from `ready` to `valid`.
- Latency is 1 cycle from the handshake to `rf_we`. The regfile's write-through bypass makes the value visible to readers in the `rf_we` cycle.
- Throughput is one write per cycle. Back-to-back grants to the same source are allowed.
- Worst-case wait for LSU/MDU is STARVE_LIMIT+1 cycles from the first denied cycle (both starving, losing the `rr` tie).

## Structure
- Shared constants go in the common `define.v` header:
  - source encodings `SRC_ALU`, `SRC_LSU`, `SRC_MDU`, `SRC_NONE`;
  - `XLEN`;
  - `RF_AW=5`.
- Sub-module `wb_wait_ctr`: saturating wait counter with `inc`, `clr` and `sat` outputs. It is instantiated twice (LSU, MDU).
- Grant logic and the output register stay in the top module.

## Test plan
- **ALU only.** Input: `alu_valid`, `waddr=5`, `wdata=0x1234`. Expect: `alu_ready=1` the same cycle; next cycle `rf_we=1`, `rf_waddr=5`, `rf_wdata=0x1234`, `grant_src=0`.
- **All three valid, non-x0, held, STARVE_LIMIT=4.**
  - Cycles 0-3: ALU granted.
  - Cycle 4: LSU granted, `alu_ready=0` (both LSU and MDU starving; `rr=0` picks LSU).
  - Cycle 5: MDU granted (still saturated), `alu_ready=0`.
  - Cycle 6: ALU resumes.
- **x0 request alongside a write.** Input: `lsu_valid`, `waddr=0`, `wdata=0xFFFF`, plus ALU `waddr=3`. Expect: both ready the same cycle; next cycle one write to x3 only; `rr` and `lsu_wait` unchanged.
- **LSU and MDU only, both valid from reset.** Expect: LSU granted first, MDU next, `rr` toggling 0→1→0; `rf_we` high on consecutive cycles.
- **Reset mid-operation.** Drop `rst_n` asynchronously while `rf_we=1`. Expect: `rf_we`, `rf_waddr`, `rf_wdata` go to 0 and `grant_src` to 3 before the next edge; all readies are 0. After release with an LSU/MDU tie, LSU is granted first.
- **Wait counter clear on deassert.** LSU is denied for 3 cycles, deasserts `valid` for 1 cycle, then reasserts. Expect: the counter restarts from 0, and pre-emption occurs only after 4 further denied cycles.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file write-back arbiter.
// Holds the source encodings, address width and the default data width.
package rf_wb_arbiter_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;
  localparam int unsigned RF_AW        = 5;
  localparam int unsigned WAIT_W       = 4;
  localparam int unsigned SRC_W        = 2;

  typedef enum logic [SRC_W-1:0] {
    SRC_ALU  = 2'd0,
    SRC_LSU  = 2'd1,
    SRC_MDU  = 2'd2,
    SRC_NONE = 2'd3
  } src_e;

  // A request that actually needs the write port (x0 writes are discarded).
  function automatic logic is_wr(input logic valid, input logic [RF_AW-1:0] waddr);
    return valid && (waddr != '0);
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_wait_ctr.sv
// Saturating wait counter: counts consecutive denied cycles of one requester.
// sat is high once the count has reached LIMIT.
module wb_wait_ctr
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  // Clear wins over increment; the count never passes LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != WAIT_W'(LIMIT))) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == WAIT_W'(LIMIT));

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the integer register file's single write port.
// ALU has priority; LSU/MDU pre-empt it after STARVE_LIMIT denied cycles.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEFAULT,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [RF_AW-1:0] alu_waddr,
  input  logic [XLEN-1:0]  alu_wdata,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [RF_AW-1:0] lsu_waddr,
  input  logic [XLEN-1:0]  lsu_wdata,
  input  logic             mdu_valid,
  output logic             mdu_ready,
  input  logic [RF_AW-1:0] mdu_waddr,
  input  logic [XLEN-1:0]  mdu_wdata,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [SRC_W-1:0] grant_src
);

  logic alu_req;
  logic lsu_req;
  logic mdu_req;
  logic lsu_sat;
  logic mdu_sat;
  logic lsu_starve;
  logic mdu_starve;
  src_e gnt;

  logic             rr_q;
  logic             rr_d;
  logic             rf_we_q;
  logic             rf_we_d;
  logic [RF_AW-1:0] rf_waddr_q;
  logic [RF_AW-1:0] rf_waddr_d;
  logic [XLEN-1:0]  rf_wdata_q;
  logic [XLEN-1:0]  rf_wdata_d;
  src_e             grant_src_q;
  src_e             grant_src_d;

  assign alu_req    = is_wr(alu_valid, alu_waddr);
  assign lsu_req    = is_wr(lsu_valid, lsu_waddr);
  assign mdu_req    = is_wr(mdu_valid, mdu_waddr);
  assign lsu_starve = lsu_req && lsu_sat;
  assign mdu_starve = mdu_req && mdu_sat;

  // Grant selection: starving low-priority sources, then ALU, then round-robin.
  always_comb begin
    gnt = SRC_NONE;
    if (lsu_starve && mdu_starve) begin
      gnt = rr_q ? SRC_MDU : SRC_LSU;
    end else if (lsu_starve) begin
      gnt = SRC_LSU;
    end else if (mdu_starve) begin
      gnt = SRC_MDU;
    end else if (alu_req) begin
      gnt = SRC_ALU;
    end else if (lsu_req && mdu_req) begin
      gnt = rr_q ? SRC_MDU : SRC_LSU;
    end else if (lsu_req) begin
      gnt = SRC_LSU;
    end else if (mdu_req) begin
      gnt = SRC_MDU;
    end
  end

  // x0 requests are acknowledged immediately and dropped; nothing is ready in reset.
  assign alu_ready = rst_n && ((alu_valid && (alu_waddr == '0)) || (gnt == SRC_ALU));
  assign lsu_ready = rst_n && ((lsu_valid && (lsu_waddr == '0)) || (gnt == SRC_LSU));
  assign mdu_ready = rst_n && ((mdu_valid && (mdu_waddr == '0)) || (gnt == SRC_MDU));

  wb_wait_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_lsu_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (lsu_req && (gnt != SRC_LSU)),
    .clr   (!lsu_valid || (gnt == SRC_LSU)),
    .sat   (lsu_sat)
  );

  wb_wait_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_mdu_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mdu_req && (gnt != SRC_MDU)),
    .clr   (!mdu_valid || (gnt == SRC_MDU)),
    .sat   (mdu_sat)
  );

  // Next write-port state; address/data hold when nothing is granted.
  always_comb begin
    rr_d        = rr_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    grant_src_d = SRC_NONE;
    unique case (gnt)
      SRC_ALU: begin
        rf_we_d     = 1'b1;
        rf_waddr_d  = alu_waddr;
        rf_wdata_d  = alu_wdata;
        grant_src_d = SRC_ALU;
      end
      SRC_LSU: begin
        rf_we_d     = 1'b1;
        rf_waddr_d  = lsu_waddr;
        rf_wdata_d  = lsu_wdata;
        grant_src_d = SRC_LSU;
        rr_d        = 1'b1;
      end
      SRC_MDU: begin
        rf_we_d     = 1'b1;
        rf_waddr_d  = mdu_waddr;
        rf_wdata_d  = mdu_wdata;
        grant_src_d = SRC_MDU;
        rr_d        = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      grant_src_q <= SRC_NONE;
    end else begin
      rr_q        <= rr_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      grant_src_q <= grant_src_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign grant_src = grant_src_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a cycle model predicts readies and the
// registered write; a monitor pops predictions and compares against the port.
module tb_rf_wb_arbiter;

  localparam int unsigned XLEN = 64;
  localparam int          LIM  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            alu_valid = 1'b0, lsu_valid = 1'b0, mdu_valid = 1'b0;
  logic [4:0]      alu_waddr = '0, lsu_waddr = '0, mdu_waddr = '0;
  logic [XLEN-1:0] alu_wdata = '0, lsu_wdata = '0, mdu_wdata = '0;
  logic            alu_ready, lsu_ready, mdu_ready;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [1:0]      grant_src;

  rf_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .grant_src(grant_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            we;
    logic [1:0]      src;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   glog[$];
  int   n_err = 0;
  int   n_chk = 0;

  // Reference state: wait counts, round-robin pointer, held write-port contents.
  int              m_lw = 0, m_mw = 0, m_rr = 0;
  logic [4:0]      m_addr = '0;
  logic [XLEN-1:0] m_data = '0;
  logic            e_alu = 1'b0, e_lsu = 1'b0, e_mdu = 1'b0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_step();
    bit ar, lr, mr, ls, ms;
    int g;
    exp_t e;
    ar = alu_valid && (alu_waddr != 0);
    lr = lsu_valid && (lsu_waddr != 0);
    mr = mdu_valid && (mdu_waddr != 0);
    ls = lr && (m_lw == LIM);
    ms = mr && (m_mw == LIM);
    g = 3;
    if (ls || ms)       g = (ls && ms) ? (m_rr != 0 ? 2 : 1) : (ls ? 1 : 2);
    else if (ar)        g = 0;
    else if (lr && mr)  g = (m_rr != 0) ? 2 : 1;
    else if (lr)        g = 1;
    else if (mr)        g = 2;
    e_alu = alu_valid && (alu_waddr == 0 || g == 0);
    e_lsu = lsu_valid && (lsu_waddr == 0 || g == 1);
    e_mdu = mdu_valid && (mdu_waddr == 0 || g == 2);
    check("alu_ready", XLEN'(alu_ready), XLEN'(e_alu));
    check("lsu_ready", XLEN'(lsu_ready), XLEN'(e_lsu));
    check("mdu_ready", XLEN'(mdu_ready), XLEN'(e_mdu));
    if (g == 0) begin m_addr = alu_waddr; m_data = alu_wdata; end
    if (g == 1) begin m_addr = lsu_waddr; m_data = lsu_wdata; m_rr = 1; end
    if (g == 2) begin m_addr = mdu_waddr; m_data = mdu_wdata; m_rr = 0; end
    e.we = (g != 3); e.src = 2'(g); e.addr = m_addr; e.data = m_data;
    exp_q.push_back(e);
    if (!lsu_valid || g == 1) m_lw = 0;
    else if (lr && m_lw < LIM) m_lw++;
    if (!mdu_valid || g == 2) m_mw = 0;
    else if (mr && m_mw < LIM) m_mw++;
  endtask

  // Model evaluates mid-cycle, when inputs and readies are settled.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_lw = 0; m_mw = 0; m_rr = 0; m_addr = '0; m_data = '0;
      e_alu = 1'b0; e_lsu = 1'b0; e_mdu = 1'b0;
      exp_q.delete();
      check("ready_in_reset", XLEN'({alu_ready, lsu_ready, mdu_ready}), XLEN'(0));
    end else begin
      model_step();
    end
  end

  // Monitor: compare the registered port against the oldest prediction.
  always @(posedge clk) begin
    #2;
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("rf_we",     XLEN'(rf_we),     XLEN'(mon_e.we));
      check("grant_src", XLEN'(grant_src), XLEN'(mon_e.src));
      check("rf_waddr",  XLEN'(rf_waddr),  XLEN'(mon_e.addr));
      check("rf_wdata",  rf_wdata,         mon_e.data);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic run_log(input int n);
    glog.delete();
    repeat (n) begin
      @(posedge clk); #3;
      glog.push_back(int'(grant_src));
    end
  endtask

  task automatic check_log(input string name, input int exp[$]);
    check({name, "_len"}, XLEN'(glog.size()), XLEN'(exp.size()));
    for (int i = 0; i < exp.size() && i < glog.size(); i++)
      check(name, XLEN'(glog[i]), XLEN'(exp[i]));
  endtask

  task automatic idle();
    alu_valid = 1'b0; lsu_valid = 1'b0; mdu_valid = 1'b0;
  endtask

  task automatic new_req(output logic v, output logic [4:0] a, output logic [XLEN-1:0] d);
    v = ($urandom_range(0, 99) < 70);
    a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    d = {$urandom, $urandom};
  endtask

  initial begin
    // Reset values, with requests present that must not be acknowledged.
    #1 rst_n = 1'b0;
    alu_valid = 1'b1; alu_waddr = 5'd5;
    lsu_valid = 1'b1; lsu_waddr = 5'd0;
    #3;
    check("rst_rf_we",     XLEN'(rf_we), XLEN'(0));
    check("rst_rf_waddr",  XLEN'(rf_waddr), XLEN'(0));
    check("rst_rf_wdata",  rf_wdata, XLEN'(0));
    check("rst_grant_src", XLEN'(grant_src), XLEN'(3));
    check("rst_alu_ready", XLEN'(alu_ready), XLEN'(0));
    check("rst_lsu_ready", XLEN'(lsu_ready), XLEN'(0));
    idle();
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // ALU only.
    alu_valid = 1'b1; alu_waddr = 5'd5; alu_wdata = XLEN'(64'h1234);
    run_log(1);
    check_log("alu_only", '{0});
    check("alu_only_wdata", rf_wdata, XLEN'(64'h1234));
    idle();
    cyc();

    // All three held: four ALU grants, then LSU, MDU, ALU again.
    alu_valid = 1'b1; alu_waddr = 5'd1; alu_wdata = XLEN'(64'hA1);
    lsu_valid = 1'b1; lsu_waddr = 5'd2; lsu_wdata = XLEN'(64'hB2);
    mdu_valid = 1'b1; mdu_waddr = 5'd3; mdu_wdata = XLEN'(64'hC3);
    run_log(7);
    check_log("starve_seq", '{0, 0, 0, 0, 1, 2, 0});
    idle();
    cyc();

    // x0 request alongside a real write.
    alu_valid = 1'b1; alu_waddr = 5'd3; alu_wdata = XLEN'(64'h33);
    lsu_valid = 1'b1; lsu_waddr = 5'd0; lsu_wdata = XLEN'(64'hFFFF);
    run_log(1);
    check_log("x0_side", '{0});
    check("x0_side_waddr", XLEN'(rf_waddr), XLEN'(3));
    idle();
    cyc();

    // LSU and MDU only, straight out of reset.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    lsu_valid = 1'b1; lsu_waddr = 5'd10; lsu_wdata = XLEN'(64'h10);
    mdu_valid = 1'b1; mdu_waddr = 5'd11; mdu_wdata = XLEN'(64'h11);
    run_log(4);
    check_log("lsu_mdu_rr", '{1, 2, 1, 2});
    idle();
    cyc();

    // Asynchronous reset while a write is on the port.
    alu_valid = 1'b1; alu_waddr = 5'd9; alu_wdata = XLEN'(64'hABCD);
    @(posedge clk); #3;
    check("pre_rst_we", XLEN'(rf_we), XLEN'(1));
    rst_n = 1'b0;
    #1;
    check("async_rf_we",     XLEN'(rf_we), XLEN'(0));
    check("async_rf_waddr",  XLEN'(rf_waddr), XLEN'(0));
    check("async_rf_wdata",  rf_wdata, XLEN'(0));
    check("async_grant_src", XLEN'(grant_src), XLEN'(3));
    check("async_alu_ready", XLEN'(alu_ready), XLEN'(0));
    alu_valid = 1'b0;
    lsu_valid = 1'b1; lsu_waddr = 5'd12; lsu_wdata = XLEN'(64'h12);
    mdu_valid = 1'b1; mdu_waddr = 5'd13; mdu_wdata = XLEN'(64'h13);
    #1;
    check("async_lsu_ready", XLEN'(lsu_ready), XLEN'(0));
    check("async_mdu_ready", XLEN'(mdu_ready), XLEN'(0));
    @(posedge clk); #3;
    rst_n = 1'b1;
    run_log(1);
    check_log("post_rst_tie", '{1});
    idle();
    cyc();

    // Wait counter clears when LSU drops valid for a cycle.
    alu_valid = 1'b1; alu_waddr = 5'd4; alu_wdata = XLEN'(64'h44);
    lsu_valid = 1'b1; lsu_waddr = 5'd7; lsu_wdata = XLEN'(64'h77);
    run_log(3);
    check_log("wait_pre", '{0, 0, 0});
    lsu_valid = 1'b0;
    run_log(1);
    check_log("wait_gap", '{0});
    lsu_valid = 1'b1;
    run_log(5);
    check_log("wait_restart", '{0, 0, 0, 0, 1});
    idle();
    cyc();

    // Randomized traffic obeying the hold-until-transfer rule.
    repeat (3000) begin
      cyc();
      if (!alu_valid || e_alu) new_req(alu_valid, alu_waddr, alu_wdata);
      if (!lsu_valid || e_lsu) new_req(lsu_valid, lsu_waddr, lsu_wdata);
      if (!mdu_valid || e_mdu) new_req(mdu_valid, mdu_waddr, mdu_wdata);
    end
    cyc();
    idle();
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
